// File: rtl/inst_realign_if.sv
// inst_realign_if: fetch-side and decode-side handshakes
// of the instruction realignment buffer.
interface inst_realign_if;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_is_rvc;

  modport slave (
    input  fetch_valid,
    input  fetch_data,
    input  inst_ready,
    output fetch_ready,
    output inst_valid,
    output inst,
    output inst_pc,
    output inst_is_rvc
  );

  modport master (
    output fetch_valid,
    output fetch_data,
    output inst_ready,
    input  fetch_ready,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    input  inst_is_rvc
  );
endinterface

// File: rtl/inst_realign.sv
// inst_realign: halfword realignment buffer between fetch and decode.
// Splits aligned fetch words into 16/32-bit instructions, expanding RVC.
module inst_realign #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [63:0]   flush_pc,
  inst_realign_if.slave bus
);

  function automatic logic [31:0] expand(input logic [15:0] c);
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [4:0]  rhi;
    logic [4:0]  rlo;
    logic [31:0] r;
    rd  = c[11:7];
    rs2 = c[6:2];
    rhi = {2'b01, c[9:7]};
    rlo = {2'b01, c[4:2]};
    r   = 32'h0;
    case ({c[1:0], c[15:13]})
      5'b00_000:
        if (c[12:5] != 8'h0)
          r = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b0,
               5'd2, 3'b000, rlo, 7'h13};
      5'b00_001:
        r = {4'b0, c[6:5], c[12:10], 3'b0,
             rhi, 3'b011, rlo, 7'h07};
      5'b00_010:
        r = {5'b0, c[5], c[12:10], c[6], 2'b0,
             rhi, 3'b010, rlo, 7'h03};
      5'b00_011:
        r = {4'b0, c[6:5], c[12:10], 3'b0,
             rhi, 3'b011, rlo, 7'h03};
      5'b00_101:
        r = {4'b0, c[6:5], c[12], rlo, rhi,
             3'b011, c[11:10], 3'b0, 7'h27};
      5'b00_110:
        r = {5'b0, c[5], c[12], rlo, rhi,
             3'b010, c[11:10], c[6], 2'b0, 7'h23};
      5'b00_111:
        r = {4'b0, c[6:5], c[12], rlo, rhi,
             3'b011, c[11:10], 3'b0, 7'h23};
      5'b01_000:
        r = {{6{c[12]}}, c[12], c[6:2], rd, 3'b000, rd, 7'h13};
      5'b01_001:
        if (rd != 5'd0)
          r = {{6{c[12]}}, c[12], c[6:2], rd, 3'b000, rd, 7'h1b};
      5'b01_010:
        r = {{6{c[12]}}, c[12], c[6:2], 5'd0, 3'b000, rd, 7'h13};
      5'b01_011:
        if ({c[12], c[6:2]} != 6'd0) begin
          if (rd == 5'd2)
            r = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0,
                 5'd2, 3'b000, 5'd2, 7'h13};
          else
            r = {{15{c[12]}}, c[6:2], rd, 7'h37};
        end
      5'b01_100:
        case (c[11:10])
          2'b00:
            r = {6'b0, c[12], c[6:2], rhi, 3'b101, rhi, 7'h13};
          2'b01:
            r = {6'b010000, c[12], c[6:2], rhi, 3'b101, rhi, 7'h13};
          2'b10:
            r = {{6{c[12]}}, c[12], c[6:2], rhi, 3'b111, rhi, 7'h13};
          default:
            case ({c[12], c[6:5]})
              3'b000: r = {7'h20, rlo, rhi, 3'b000, rhi, 7'h33};
              3'b001: r = {7'h00, rlo, rhi, 3'b100, rhi, 7'h33};
              3'b010: r = {7'h00, rlo, rhi, 3'b110, rhi, 7'h33};
              3'b011: r = {7'h00, rlo, rhi, 3'b111, rhi, 7'h33};
              3'b100: r = {7'h20, rlo, rhi, 3'b000, rhi, 7'h3b};
              3'b101: r = {7'h00, rlo, rhi, 3'b000, rhi, 7'h3b};
              default: r = 32'h0;
            endcase
        endcase
      5'b01_101:
        r = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3],
             c[12], {8{c[12]}}, 5'd0, 7'h6f};
      5'b01_110:
        r = {{4{c[12]}}, c[6:5], c[2], 5'd0, rhi, 3'b000,
             c[11:10], c[4:3], c[12], 7'h63};
      5'b01_111:
        r = {{4{c[12]}}, c[6:5], c[2], 5'd0, rhi, 3'b001,
             c[11:10], c[4:3], c[12], 7'h63};
      5'b10_000:
        r = {6'b0, c[12], c[6:2], rd, 3'b001, rd, 7'h13};
      5'b10_001:
        r = {3'b0, c[4:2], c[12], c[6:5], 3'b0,
             5'd2, 3'b011, rd, 7'h07};
      5'b10_010:
        if (rd != 5'd0)
          r = {4'b0, c[3:2], c[12], c[6:4], 2'b0,
               5'd2, 3'b010, rd, 7'h03};
      5'b10_011:
        if (rd != 5'd0)
          r = {3'b0, c[4:2], c[12], c[6:5], 3'b0,
               5'd2, 3'b011, rd, 7'h03};
      5'b10_100:
        if (!c[12]) begin
          if (rs2 == 5'd0) begin
            if (rd != 5'd0)
              r = {12'b0, rd, 3'b000, 5'd0, 7'h67};
          end else begin
            r = {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
          end
        end else begin
          if (rs2 == 5'd0) begin
            if (rd == 5'd0)
              r = 32'h0010_0073;
            else
              r = {12'b0, rd, 3'b000, 5'd1, 7'h67};
          end else begin
            r = {7'b0, rs2, rd, 3'b000, rd, 7'h33};
          end
        end
      5'b10_101:
        r = {3'b0, c[9:7], c[12], rs2, 5'd2,
             3'b011, c[11:10], 3'b0, 7'h27};
      5'b10_110:
        r = {4'b0, c[8:7], c[12], rs2, 5'd2,
             3'b010, c[11:9], 2'b0, 7'h23};
      5'b10_111:
        r = {3'b0, c[9:7], c[12], rs2, 5'd2,
             3'b011, c[11:10], 3'b0, 7'h23};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  logic [15:0] slot_q [4];
  logic [15:0] slot_d [4];
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic [63:0] pc_q;
  logic [63:0] pc_d;
  logic        drop_q;
  logic        drop_d;

  logic        is32;
  logic        cand;
  logic        pop;
  logic        acc;
  logic [2:0]  npop;
  logic [2:0]  npush;
  logic [2:0]  rem;
  logic [15:0] hw0;
  logic [15:0] hw1;

  assign is32  = (slot_q[0][1:0] == 2'b11);
  assign cand  = is32 ? (cnt_q >= 3'd2) : (cnt_q >= 3'd1);

  assign bus.inst_valid  = cand && !flush;
  assign bus.fetch_ready = rst_n && (cnt_q <= 3'd2) && !flush;
  assign bus.inst        = is32 ? {slot_q[1], slot_q[0]}
                                : expand(slot_q[0]);
  assign bus.inst_pc     = pc_q;
  assign bus.inst_is_rvc = !is32;

  assign pop   = bus.inst_valid && bus.inst_ready;
  assign acc   = bus.fetch_valid && bus.fetch_ready;
  assign npop  = !pop ? 3'd0 : (is32 ? 3'd2 : 3'd1);
  assign npush = !acc ? 3'd0 : (drop_q ? 3'd1 : 3'd2);
  assign rem   = cnt_q - npop;
  assign hw0   = drop_q ? bus.fetch_data[31:16]
                        : bus.fetch_data[15:0];
  assign hw1   = bus.fetch_data[31:16];

  // Next state: shift out popped halfwords, append accepted ones behind.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      slot_d[i] = slot_q[i];
      if (3'(i) < rem)
        slot_d[i] = slot_q[2'(i) + npop[1:0]];
      else if (acc && 3'(i) == rem)
        slot_d[i] = hw0;
      else if (acc && !drop_q && 3'(i) == rem + 3'd1)
        slot_d[i] = hw1;
    end
    cnt_d  = rem + npush;
    pc_d   = pc_q + (pop ? (is32 ? 64'd4 : 64'd2) : 64'd0);
    drop_d = acc ? 1'b0 : drop_q;
    if (flush) begin
      cnt_d  = 3'd0;
      pc_d   = flush_pc & ~64'd1;
      drop_d = flush_pc[1];
    end
  end

  // Buffer, count, PC and drop-low registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 3'd0;
      pc_q   <= RESET_PC & ~64'd1;
      drop_q <= RESET_PC[1];
      for (int i = 0; i < 4; i++) slot_q[i] <= 16'h0;
    end else begin
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
      drop_q <= drop_d;
      for (int i = 0; i < 4; i++) slot_q[i] <= slot_d[i];
    end
  end

endmodule
